qam_stream_mapper: RTL and testbench
====================================

# qam_stream_mapper

Streaming, run-time-configurable QAM mapper for the transceiver TX path. It sits between the byte-oriented payload source and the OFDM subcarrier mapper. It accepts bytes over a valid/ready handshake and unpacks them into 2-, 4- or 6-bit symbol indices (QPSK / 16-QAM / 64-QAM). Each index is looked up in a writable constellation table and emitted as a registered Q5.13 real/imag pair with frame-end marking.

## Interface
- `IN_WIDTH`, 8, input byte width in bits
- `MAX_BPS`, 6, largest bits-per-symbol supported; table depth is `2**MAX_BPS`
- `OUTPUT_DATA_WIDTH`, 18, output sample width (Q5.13)
- `INTEGER_PART`, 5, integer bits; fractional part `FIX_POINT_PART = OUTPUT_DATA_WIDTH - INTEGER_PART`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  2  0 = QPSK (2 bps), 1 = 16-QAM (4), 2 = 64-QAM (6), 3 = treated as 16-QAM
- `s_valid` / `s_ready`  in / out  1  input handshake
- `s_data`  in  `IN_WIDTH`  payload byte, consumed LSB first
- `s_last`  in  1  final byte of frame
- `tbl_we`  in  1  table write strobe
- `tbl_addr`  in  `MAX_BPS`  table index
- `tbl_re`, `tbl_im`  in  `INTEGER_PART` each  signed integer coordinates
- `m_valid` / `m_ready`  out / in  1  output handshake
- `m_real`, `m_imag`  out  `OUTPUT_DATA_WIDTH`  `{entry, FIX_POINT_PART zeros}`
- `m_last`  out  1  final symbol of frame

## Operation
- Accumulator `acc` (`IN_WIDTH+MAX_BPS-1` bits) and bit count `cnt`.
- `bps` is latched from `mode` on the first accepted byte of a frame (IDLE→RUN). `mode` changes mid-frame are ignored.
- `s_ready = (state != FLUSH) && (cnt < bps)`. In IDLE, `bps` is taken from the live `mode`.
- Byte accept:
  - `acc |= s_data << cnt`, `cnt += IN_WIDTH`.
  - If `s_last` is set, set `last_pending`.
- Emit condition: `cnt >= bps && (!m_valid || m_ready)`. On emit:
  - `idx = acc[bps-1:0]` (first bit received is the index LSB).
  - `acc >>= bps`, `cnt -= bps`.
  - The output register loads the table entry.
- Accept and emit are mutually exclusive by construction (`cnt < bps` vs `cnt >= bps`).
- States:
  - **IDLE:** `cnt == 0`, no frame.
  - **RUN:** frame in progress.
  - **FLUSH:** `last_pending` set, `0 < cnt < bps`. Emits one symbol with the index zero-padded in the upper bits and `m_last = 1`, then goes to IDLE.
- `m_last` on a normal emit: set when `last_pending` and the remaining `cnt` after the emit is 0. That emit returns the FSM to IDLE.
- Table:
  - Register array of `2**MAX_BPS` entries, `{im, re}`, not reset.
  - Written whenever `tbl_we` is high, independent of state.
  - A lookup in the same cycle as a write to the same address returns the old entry.
- Reset (any time, including mid-frame):
  - `acc`, `cnt` and `last_pending` clear, FSM goes to IDLE.
  - Buffered partial bits are discarded.
  - Table contents are retained.

## Timing
- Reset values: `s_ready = 1`, `m_valid = 0`, `m_last = 0`, `m_real = 0`, `m_imag = 0`.
- Latency: byte accepted at edge N gives its first symbol on `m_valid` after edge N+1.
- Output hold: `m_valid`, data and `m_last` hold stable while `m_valid && !m_ready`. `s_ready` drops once `cnt >= bps`.
- Throughput with continuous `m_ready`:
  - QPSK: 4 symbols per 5 cycles.
  - 16-QAM: 2 per 3.
  - 64-QAM: 4 symbols per 3 bytes plus flush cycles.
- Back-to-back frames: the next frame's first byte is accepted the cycle after the final symbol is loaded (IDLE, `cnt = 0`).

## Configuration
- `QAM_FLUSH_PAD_EN` defined: the FLUSH state exists; leftover bits at frame end are zero-padded and emitted as a final symbol with `m_last`.
- Not defined: leftover bits (`cnt < bps`) are dropped. `m_last` is set on the last full symbol (remaining `cnt < bps` after emit), and the FSM returns to IDLE.

## Test plan
- **16-QAM lookup:** load entry 0x1 re=3 im=−3 and entry 0xB re=−1 im=1, `mode = 1`, send byte 0xB1 with `s_last`. Expect two outputs:
  - Symbol 1: `m_real = 0x06000`, `m_imag = 0x3A000`, `m_last = 0`.
  - Symbol 2: `m_real = 0x3E000`, `m_imag = 0x02000`, `m_last = 1`.
- **64-QAM with pad:** `mode = 2`, bytes 0xFF, 0x0F(last). Indices 0x3F, 0x3F, then 0x00.
  - With `QAM_FLUSH_PAD_EN`: third output (index 0x00) carries `m_last`.
  - Without it: only two outputs, the second with `m_last`.
- **Backpressure:** `m_ready` low for 5 cycles mid-frame. Output data and `m_valid` remain constant, `s_ready = 0`, no symbol lost or duplicated afterward.
- **Table collision:** write entry 0x1 to re=2 in the same cycle index 0x1 is emitted. The output shows the old value; the next use of 0x1 shows `0x04000`.
- **Reset mid-frame:** assert `rst` after one byte of a QPSK frame. Outputs return to reset values next cycle; a new frame's first symbol uses its own bits only, and table entries are unchanged.
- **QPSK throughput:** 4 bytes streamed, `m_ready = 1`. Expect 16 symbols in 20 cycles, with `mode` toggled mid-frame having no effect.

Source files
------------

// File: rtl/qam_stream_mapper_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qam_stream_mapper_if                                                 |
// | Byte-in / symbol-out stream bundle for qam_stream_mapper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface qam_stream_mapper_if #(
  parameter int IN_WIDTH          = 8,
  parameter int OUTPUT_DATA_WIDTH = 18
);
  logic                         s_valid;
  logic                         s_ready;
  logic [IN_WIDTH-1:0]          s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [OUTPUT_DATA_WIDTH-1:0] m_real;
  logic [OUTPUT_DATA_WIDTH-1:0] m_imag;
  logic                         m_last;

  // slave: the mapper itself; master: byte source / symbol sink side
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_last
  );
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_last
  );
endinterface
`default_nettype wire

// File: rtl/qam_stream_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qam_stream_mapper                                                    |
// | Unpacks bytes into 2/4/6-bit indices and maps them through a         |
// | writable constellation table to registered Q5.13 real/imag pairs.   |
// | Option macro: QAM_FLUSH_PAD_EN (zero-pad and emit leftover bits).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module qam_stream_mapper #(
  parameter int IN_WIDTH          = 8,
  parameter int MAX_BPS           = 6,
  parameter int OUTPUT_DATA_WIDTH = 18,
  parameter int INTEGER_PART      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode_i,
  input  logic                    tbl_we_i,
  input  logic [MAX_BPS-1:0]      tbl_addr_i,
  input  logic [INTEGER_PART-1:0] tbl_re_i,
  input  logic [INTEGER_PART-1:0] tbl_im_i,
  qam_stream_mapper_if.slave      bus
);

  localparam int FIX_POINT_PART = OUTPUT_DATA_WIDTH - INTEGER_PART;
  localparam int ACC_W          = IN_WIDTH + MAX_BPS - 1;
  localparam int CNT_W          = $clog2(ACC_W + 1);
  localparam int BPS_W          = $clog2(MAX_BPS + 1);
  localparam int DEPTH          = 2 ** MAX_BPS;
  localparam int ENT_W          = 2 * INTEGER_PART;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1
`ifdef QAM_FLUSH_PAD_EN
    , ST_FLUSH = 2'd2
`endif
  } state_e;

  state_e                         state_q, state_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BPS_W-1:0]               bps_q, bps_d;
  logic                           last_pend_q, last_pend_d;
  logic                           m_valid_q, m_valid_d;
  logic                           m_last_q, m_last_d;
  logic [OUTPUT_DATA_WIDTH-1:0]   m_real_q, m_real_d;
  logic [OUTPUT_DATA_WIDTH-1:0]   m_imag_q, m_imag_d;

  logic [ENT_W-1:0]               tbl_q [DEPTH];

  logic [BPS_W-1:0]               mode_bps;
  logic [BPS_W-1:0]               bps_w;
  logic [CNT_W-1:0]               bps_c;
  logic [CNT_W-1:0]               cnt_rem;
  logic [MAX_BPS-1:0]             idx_mask;
  logic [MAX_BPS-1:0]             idx;
  logic [ENT_W-1:0]               entry;
  logic                           s_ready_w;
  logic                           accept;
  logic                           can_load;
  logic                           emit;
  logic                           flush_emit;

  always_comb begin
    case (mode_i)
      2'd0:    mode_bps = BPS_W'(2);
      2'd2:    mode_bps = BPS_W'(6);
      default: mode_bps = BPS_W'(4);
    endcase
  end

  // Table is deliberately outside the reset domain; reads see the pre-write entry.
  always_ff @(posedge clk) begin
    if (tbl_we_i) begin
      tbl_q[tbl_addr_i] <= {tbl_im_i, tbl_re_i};
    end
  end

  always_comb begin
    bps_w   = (state_q == ST_IDLE) ? mode_bps : bps_q;
    bps_c   = CNT_W'(bps_w);
    cnt_rem = cnt_q - bps_c;
    idx_mask = '0;
    for (int i = 0; i < MAX_BPS; i++) begin
      idx_mask[i] = (i < int'(bps_w));
    end
    idx      = acc_q[MAX_BPS-1:0] & idx_mask;
    entry    = tbl_q[idx];
    can_load = !m_valid_q || bus.m_ready;
`ifdef QAM_FLUSH_PAD_EN
    s_ready_w  = (state_q != ST_FLUSH) && (cnt_q < bps_c);
    flush_emit = (state_q == ST_FLUSH) && can_load;
`else
    s_ready_w  = (cnt_q < bps_c);
    flush_emit = 1'b0;
`endif
    accept = bus.s_valid && s_ready_w;
    emit   = (cnt_q >= bps_c) && can_load;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bps_d       = bps_q;
    last_pend_d = last_pend_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_real_d    = m_real_q;
    m_imag_d    = m_imag_q;

    if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      acc_d = acc_q | (ACC_W'(bus.s_data) << cnt_q);
      cnt_d = cnt_q + CNT_W'(IN_WIDTH);
      if (bus.s_last) begin
        last_pend_d = 1'b1;
      end
      if (state_q == ST_IDLE) begin
        bps_d   = mode_bps;
        state_d = ST_RUN;
      end
    end

    if (emit || flush_emit) begin
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      m_real_d  = {entry[INTEGER_PART-1:0], {FIX_POINT_PART{1'b0}}};
      m_imag_d  = {entry[ENT_W-1:INTEGER_PART], {FIX_POINT_PART{1'b0}}};
    end

    if (emit) begin
      acc_d = acc_q >> bps_w;
      cnt_d = cnt_rem;
      if (last_pend_q) begin
        if (cnt_rem == '0) begin
          m_last_d    = 1'b1;
          last_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_rem < bps_c) begin
`ifdef QAM_FLUSH_PAD_EN
          state_d = ST_FLUSH;
`else
          // Frame tail shorter than a symbol is discarded.
          m_last_d    = 1'b1;
          last_pend_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
`endif
        end
      end
    end

    if (flush_emit) begin
      m_last_d    = 1'b1;
      last_pend_d = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bps_q       <= BPS_W'(4);
      last_pend_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_real_q    <= '0;
      m_imag_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bps_q       <= bps_d;
      last_pend_q <= last_pend_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_real_q    <= m_real_d;
      m_imag_q    <= m_imag_d;
    end
  end

  assign bus.s_ready = s_ready_w;
  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_real  = m_real_q;
  assign bus.m_imag  = m_imag_q;

endmodule
`default_nettype wire

// File: tb/tb_qam_stream_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qam_stream_mapper                                                 |
// | Directed self-checking bench for qam_stream_mapper.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_qam_stream_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       tbl_we;
  logic [5:0] tbl_addr;
  logic [4:0] tbl_re;
  logic [4:0] tbl_im;

  qam_stream_mapper_if #(.IN_WIDTH(8), .OUTPUT_DATA_WIDTH(18)) bus ();

  qam_stream_mapper #(
    .IN_WIDTH(8), .MAX_BPS(6), .OUTPUT_DATA_WIDTH(18), .INTEGER_PART(5)
  ) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .tbl_we_i(tbl_we),
    .tbl_addr_i(tbl_addr), .tbl_re_i(tbl_re), .tbl_im_i(tbl_im), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [17:0] re;
    logic [17:0] im;
    logic        last;
  } cap_t;

  cap_t caps[$];
  int   cap_cyc[$];

  // A handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      caps.push_back({bus.m_real, bus.m_imag, bus.m_last});
      cap_cyc.push_back(cyc + 1);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int acc_cyc = 0;
  int first_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int k;
    k = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (bus.s_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("s_ready_for_byte", 64'(bus.s_ready), 64'd1);
    tick();
    acc_cyc     = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_caps(input int n);
    int k;
    k = 0;
    while (caps.size() < n && k < 100) begin
      tick();
      k++;
    end
    settle();
  endtask

  task automatic chk_cap(input string tag, input int k, input logic [35:0] exp_ri, input logic exp_last);
    cap_t c;
    c = (k < caps.size()) ? caps[k] : '0;
    chk(tag, 64'({c.re, c.im}), 64'(exp_ri));
    chk(tag, 64'(c.last), 64'(exp_last));
  endtask

  function automatic logic [35:0] qpsk_exp(input int idx);
    case (idx)
      0:       return {18'h00000, 18'h3E000};
      1:       return {18'h04000, 18'h3A000};
      2:       return {18'h04000, 18'h3A000};
      default: return {18'h06000, 18'h38000};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'd1; tbl_we = 1'b0; tbl_addr = '0; tbl_re = '0; tbl_im = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    tick(); tick();

    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_last",  64'(bus.m_last),  64'd0);
    chk("rst_m_real",  64'(bus.m_real),  64'd0);
    chk("rst_m_imag",  64'(bus.m_imag),  64'd0);

    // Base table: re = i mod 32, im = 31 - (i mod 32)
    for (int i = 0; i < 64; i++) begin
      tbl_we = 1'b1; tbl_addr = 6'(i); tbl_re = 5'(i); tbl_im = ~5'(i);
      tick();
    end
    tbl_addr = 6'h01; tbl_re = 5'd3;  tbl_im = 5'h1D; tick();
    tbl_addr = 6'h0B; tbl_re = 5'h1F; tbl_im = 5'd1;  tick();
    tbl_we = 1'b0;
    rst = 1'b0;
    tick();

    // 16-QAM lookup with latency check
    bus.m_ready = 1'b1; mode = 2'd1;
    send_byte(8'hB1, 1'b1);
    chk("lat_before_load", 64'(bus.m_valid), 64'd0);
    tick();
    chk("lat_after_load", 64'(bus.m_valid), 64'd1);
    wait_caps(2);
    chk("qam16_count", 64'(caps.size()), 64'd2);
    chk_cap("qam16_sym0", 0, {18'h06000, 18'h3A000}, 1'b0);
    chk_cap("qam16_sym1", 1, {18'h3E000, 18'h02000}, 1'b1);
    caps.delete(); cap_cyc.delete();

    // 64-QAM frame with a 4-bit tail
    mode = 2'd2;
    send_byte(8'hFF, 1'b0);
    send_byte(8'h0F, 1'b1);
    mode = 2'd1;
`ifdef QAM_FLUSH_PAD_EN
    wait_caps(3);
    chk("qam64_count", 64'(caps.size()), 64'd3);
    chk_cap("qam64_sym0", 0, {18'h3E000, 18'h00000}, 1'b0);
    chk_cap("qam64_sym1", 1, {18'h3E000, 18'h00000}, 1'b0);
    chk_cap("qam64_pad",  2, {18'h00000, 18'h3E000}, 1'b1);
`else
    wait_caps(2);
    chk("qam64_count", 64'(caps.size()), 64'd2);
    chk_cap("qam64_sym0", 0, {18'h3E000, 18'h00000}, 1'b0);
    chk_cap("qam64_sym1", 1, {18'h3E000, 18'h00000}, 1'b1);
`endif
    caps.delete(); cap_cyc.delete();

    // Backpressure: indices 1,2,3,4
    bus.m_ready = 1'b0;
    send_byte(8'h21, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 64'(bus.m_valid), 64'd1);
      chk("bp_hold_data", 64'({bus.m_real, bus.m_imag}), 64'({18'h06000, 18'h3A000}));
    end
    chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
    bus.m_ready = 1'b1;
    send_byte(8'h43, 1'b1);
    wait_caps(4);
    chk("bp_count", 64'(caps.size()), 64'd4);
    chk_cap("bp_sym0", 0, {18'h06000, 18'h3A000}, 1'b0);
    chk_cap("bp_sym1", 1, {18'h04000, 18'h3A000}, 1'b0);
    chk_cap("bp_sym2", 2, {18'h06000, 18'h38000}, 1'b0);
    chk_cap("bp_sym3", 3, {18'h08000, 18'h36000}, 1'b1);
    caps.delete(); cap_cyc.delete();

    // Table write colliding with a lookup of the same entry
    send_byte(8'h11, 1'b1);
    tbl_we = 1'b1; tbl_addr = 6'h01; tbl_re = 5'd2; tbl_im = 5'h1D;
    tick();
    tbl_we = 1'b0;
    wait_caps(2);
    chk("coll_count", 64'(caps.size()), 64'd2);
    chk_cap("coll_old", 0, {18'h06000, 18'h3A000}, 1'b0);
    chk_cap("coll_new", 1, {18'h04000, 18'h3A000}, 1'b1);
    caps.delete(); cap_cyc.delete();

    // Reset in the middle of a QPSK frame
    mode = 2'd0;
    send_byte(8'hE4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mid_rst_m_real",  64'(bus.m_real),  64'd0);
    chk("mid_rst_m_imag",  64'(bus.m_imag),  64'd0);
    chk("mid_rst_m_last",  64'(bus.m_last),  64'd0);
    chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
    rst = 1'b0;
    caps.delete(); cap_cyc.delete();
    tick();
    send_byte(8'h1B, 1'b1);
    wait_caps(4);
    chk("post_rst_count", 64'(caps.size()), 64'd4);
    chk_cap("post_rst_sym0", 0, qpsk_exp(3), 1'b0);
    chk_cap("post_rst_sym1", 1, qpsk_exp(2), 1'b0);
    chk_cap("post_rst_sym2", 2, qpsk_exp(1), 1'b0);
    chk_cap("post_rst_sym3", 3, qpsk_exp(0), 1'b1);
    caps.delete(); cap_cyc.delete();

    // QPSK throughput with a mid-frame mode change
    mode = 2'd0;
    send_byte(8'hE4, 1'b0);
    first_cyc = acc_cyc;
    send_byte(8'h1B, 1'b0);
    mode = 2'd2;
    send_byte(8'hE4, 1'b0);
    send_byte(8'h1B, 1'b1);
    mode = 2'd0;
    wait_caps(16);
    chk("tput_count", 64'(caps.size()), 64'd16);
    chk("tput_cycles", 64'((cap_cyc.size() > 15) ? cap_cyc[15] - first_cyc : 0), 64'd20);
    for (int k = 0; k < 16; k++) begin
      int s;
      s = k % 8;
      chk_cap("tput_sym", k, qpsk_exp((s < 4) ? s : 7 - s), (k == 15) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
